mul8_seq_ctrl: RTL and testbench

Sequential 8x8 unsigned multiplier built around one shared 4x4 nibble multiplier, reused over four cycles in place of four parallel units.
- Controller owns operand capture, step sequencing, shift-and-accumulate and an in/out valid/ready handshake.
- Sits between a requesting datapath stage and a result consumer; trades 4-cycle latency for a quarter of the partial-product area.

---
 rtl/mul8_seq_pkg.sv | 37 +++
 rtl/mul8_seq_ctrl_if.sv | 27 ++
 rtl/nibble_mul4.sv | 12 +
 rtl/mul8_seq_ctrl.sv | 147 ++++++++++++++
 tb/tb_mul8_seq_ctrl.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mul8_seq_pkg.sv
// Shared types and constants for the sequential 8x8 multiplier built on one nibble multiplier.
// Holds the state and step encodings and the per-step shift amounts.
package mul8_seq_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef logic [1:0] step_t;

    localparam step_t STEP0 = 2'd0;
    localparam step_t STEP1 = 2'd1;
    localparam step_t STEP2 = 2'd2;
    localparam step_t STEP3 = 2'd3;

    // Shift per step in units of one nibble: lo*lo, hi*lo, lo*hi, hi*hi.
    localparam int SHIFT_UNITS_STEP0 = 0;
    localparam int SHIFT_UNITS_STEP1 = 1;
    localparam int SHIFT_UNITS_STEP2 = 1;
    localparam int SHIFT_UNITS_STEP3 = 2;

    function automatic int step_shift(input step_t step, input int nibble_w);
        int units;
        case (step)
            STEP0:   units = SHIFT_UNITS_STEP0;
            STEP1:   units = SHIFT_UNITS_STEP1;
            STEP2:   units = SHIFT_UNITS_STEP2;
            default: units = SHIFT_UNITS_STEP3;
        endcase
        return units * nibble_w;
    endfunction

endpackage

// File: rtl/mul8_seq_ctrl_if.sv
// Operand/result handshake bundle between a requester, the multiplier and a result consumer.
interface mul8_seq_ctrl_if
    import mul8_seq_pkg::*;
#(
    parameter int N_W = NIBBLE_W
) ();

    logic               in_valid;
    logic               in_ready;
    logic [2*N_W-1:0]   a;
    logic [2*N_W-1:0]   b;
    logic               out_valid;
    logic               out_ready;
    logic [4*N_W-1:0]   product;
    logic               busy;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, product, busy
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, product, busy
    );

endinterface

// File: rtl/nibble_mul4.sv
// Purely combinational N_W x N_W unsigned multiplier, shared across all four partial products.
module nibble_mul4 #(
    parameter int N_W = 4
) (
    input  logic [N_W-1:0]   x,
    input  logic [N_W-1:0]   y,
    output logic [2*N_W-1:0] p
);

    assign p = {{N_W{1'b0}}, x} * {{N_W{1'b0}}, y};

endmodule

// File: rtl/mul8_seq_ctrl.sv
// Sequential 8x8 unsigned multiplier: one nibble multiplier reused over four accumulate steps.
// Optional macro MUL8_SEQ_ZERO_SKIP_EN short-circuits operations with a zero operand.
module mul8_seq_ctrl
    import mul8_seq_pkg::*;
#(
    parameter int N_W = NIBBLE_W
) (
    input logic            clk,
    input logic            rst,
    mul8_seq_ctrl_if.slave bus
);

    localparam int OP_W   = 2 * N_W;
    localparam int PROD_W = 4 * N_W;

    state_t            state, state_nxt;
    step_t             step, step_nxt;
    logic [OP_W-1:0]   a_r, a_nxt;
    logic [OP_W-1:0]   b_r, b_nxt;
    logic [PROD_W-1:0] acc, acc_nxt;
    logic [PROD_W-1:0] product_r, product_nxt;

    logic [N_W-1:0]    nib_a, nib_b;
    logic [OP_W-1:0]   pp;
    logic [PROD_W-1:0] pp_shifted;
    logic [PROD_W-1:0] acc_sum;
    logic              in_ready;
    logic              accept;

`ifdef MUL8_SEQ_ZERO_SKIP_EN
    // A zero-operand job parks in MUL for one cycle without computing, so busy stays low.
    logic skip_r, skip_nxt;
    logic operand_zero;

    assign operand_zero = (bus.a == '0) || (bus.b == '0);
`endif

    assign in_ready = (state == IDLE) || ((state == DONE) && bus.out_ready);
    assign accept   = bus.in_valid && in_ready;

    // step[0] picks the multiplicand nibble, step[1] the multiplier nibble.
    assign nib_a = step[0] ? a_r[OP_W-1:N_W] : a_r[N_W-1:0];
    assign nib_b = step[1] ? b_r[OP_W-1:N_W] : b_r[N_W-1:0];

    nibble_mul4 #(
        .N_W(N_W)
    ) u_nibble_mul4 (
        .x(nib_a),
        .y(nib_b),
        .p(pp)
    );

    assign pp_shifted = {{OP_W{1'b0}}, pp} << step_shift(step, N_W);
    assign acc_sum    = acc + pp_shifted;

    always_comb begin
        state_nxt   = state;
        step_nxt    = step;
        a_nxt       = a_r;
        b_nxt       = b_r;
        acc_nxt     = acc;
        product_nxt = product_r;
`ifdef MUL8_SEQ_ZERO_SKIP_EN
        skip_nxt    = skip_r;
`endif

        case (state)
            IDLE: begin
                state_nxt = IDLE;
            end
            MUL: begin
`ifdef MUL8_SEQ_ZERO_SKIP_EN
                if (skip_r) begin
                    state_nxt   = DONE;
                    product_nxt = '0;
                    skip_nxt    = 1'b0;
                end else
`endif
                begin
                    acc_nxt  = acc_sum;
                    step_nxt = step + 2'd1;
                    if (step == STEP3) begin
                        state_nxt   = DONE;
                        product_nxt = acc_sum;
                    end
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // Acceptance overrides the per-state decision, which makes DONE retire-and-accept work.
        if (accept) begin
            a_nxt     = bus.a;
            b_nxt     = bus.b;
            acc_nxt   = '0;
            step_nxt  = STEP0;
            state_nxt = MUL;
`ifdef MUL8_SEQ_ZERO_SKIP_EN
            skip_nxt  = operand_zero;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            step      <= STEP0;
            a_r       <= '0;
            b_r       <= '0;
            acc       <= '0;
            product_r <= '0;
        end else begin
            state     <= state_nxt;
            step      <= step_nxt;
            a_r       <= a_nxt;
            b_r       <= b_nxt;
            acc       <= acc_nxt;
            product_r <= product_nxt;
        end
    end

`ifdef MUL8_SEQ_ZERO_SKIP_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            skip_r <= 1'b0;
        end else begin
            skip_r <= skip_nxt;
        end
    end

    assign bus.busy = (state == MUL) && !skip_r;
`else
    assign bus.busy = (state == MUL);
`endif

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = (state == DONE);
    assign bus.product   = product_r;

endmodule

// File: tb/tb_mul8_seq_ctrl.sv
// Scoreboard bench for mul8_seq_ctrl: stimulus queues expected products, a monitor checks them.
// Zero-operand latency expectations follow MUL8_SEQ_ZERO_SKIP_EN.
module tb_mul8_seq_ctrl;

    localparam int N_W = 4;
`ifdef MUL8_SEQ_ZERO_SKIP_EN
    localparam int ZERO_LAT  = 1;
    localparam int ZERO_BUSY = 0;
`else
    localparam int ZERO_LAT  = 4;
    localparam int ZERO_BUSY = 4;
`endif

    typedef struct {
        logic [15:0] prod;
        int          acc_cyc;
        int          lat;
    } exp_t;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] prod;
        int          lat;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    int   busy_cnt = 0;
    logic [15:0] held = '0;
    logic prev_v = 1'b0;
    logic prev_r = 1'b0;

    mul8_seq_ctrl_if #(.N_W(N_W)) bus ();

    mul8_seq_ctrl #(.N_W(N_W)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) if (bus.busy) busy_cnt <= busy_cnt + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Holds the request until accepted, then queues the expected result and scrambles the operands.
    task automatic applyStimulus(input logic [7:0] av, input logic [7:0] bv,
                                 input logic [15:0] ep, input int lat, output int waits);
        exp_t e;
        bus.in_valid = 1'b1;
        bus.a = av;
        bus.b = bv;
        waits = 0;
        while (1) begin
            @(negedge clk);
            if (bus.in_ready) break;
            waits++;
            if (waits >= 50) break;
        end
        if (!bus.in_ready) begin
            n_checks++;
            n_errors++;
            $display("[TB] FAIL accept_timeout: in_ready=0 after %0d cycles, expected 1", waits);
            bus.in_valid = 1'b0;
            return;
        end
        e.prod = ep;
        e.acc_cyc = cyc + 1;
        e.lat = lat;
        sb.push_back(e);
        tick();
        bus.in_valid = 1'b0;
        bus.a = ~av;
        bus.b = ~bv;
    endtask

    task automatic waitDone;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && !bus.out_valid) begin
                tick();
                return;
            end
        end
        n_checks++;
        n_errors++;
        $display("[TB] FAIL drain_timeout: %0d results outstanding, expected 0", sb.size());
        tick();
    endtask

    task automatic waitOutValid;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (bus.out_valid) return;
        end
        n_checks++;
        n_errors++;
        $display("[TB] FAIL out_valid_timeout: out_valid=0, expected 1");
    endtask

    // Monitor: each new out_valid pops one expectation; a stalled result must stay stable.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_v = 1'b0;
                prev_r = 1'b0;
            end else begin
                if (bus.out_valid) begin
                    if (!prev_v || prev_r) begin
                        if (sb.size() == 0) begin
                            n_checks++;
                            n_errors++;
                            $display("[TB] FAIL unexpected_out_valid: product=0x%0h with nothing outstanding",
                                     bus.product);
                        end else begin
                            e = sb.pop_front();
                            checkOutput("product", 32'(bus.product), 32'(e.prod));
                            checkOutput("latency", 32'(cyc - e.acc_cyc), 32'(e.lat));
                            held = e.prod;
                        end
                    end else begin
                        checkOutput("held_product", 32'(bus.product), 32'(held));
                    end
                end
                prev_v = bus.out_valid;
                prev_r = bus.out_ready;
            end
        end
    end

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int   w;
        int   b0;
        vec_t vecs[4];

        vecs[0] = '{8'h01, 8'h01, 16'h0001, 4};
        vecs[1] = '{8'h9C, 8'h3B, 16'h23F4, 4};
        vecs[2] = '{8'h7F, 8'h81, 16'h3FFF, 4};
        vecs[3] = '{8'hFF, 8'h00, 16'h0000, ZERO_LAT};

        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.out_ready = 1'b1;
        #1;
        checkOutput("reset_in_ready", 32'(bus.in_ready), 1);
        checkOutput("reset_out_valid", 32'(bus.out_valid), 0);
        checkOutput("reset_busy", 32'(bus.busy), 0);
        checkOutput("reset_product", 32'(bus.product), 0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        $display("[TB] basic product 0x80*0x03");
        b0 = busy_cnt;
        applyStimulus(8'h80, 8'h03, 16'h0180, 4, w);
        waitDone();
        checkOutput("busy_cycles_basic", 32'(busy_cnt - b0), 4);

        $display("[TB] maximum operands 0xFF*0xFF");
        applyStimulus(8'hFF, 8'hFF, 16'hFE01, 4, w);
        waitDone();

        $display("[TB] consumer stall 0x12*0x34");
        bus.out_ready = 1'b0;
        applyStimulus(8'h12, 8'h34, 16'h03A8, 4, w);
        waitOutValid();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput("stall_out_valid", 32'(bus.out_valid), 1);
            checkOutput("stall_in_ready", 32'(bus.in_ready), 0);
            checkOutput("stall_product", 32'(bus.product), 32'h03A8);
        end
        tick();
        bus.out_ready = 1'b1;
        @(negedge clk);
        checkOutput("release_in_ready", 32'(bus.in_ready), 1);
        tick();
        checkOutput("release_out_valid", 32'(bus.out_valid), 0);
        checkOutput("release_idle_in_ready", 32'(bus.in_ready), 1);

        $display("[TB] back-to-back retire and accept");
        bus.out_ready = 1'b0;
        applyStimulus(8'h05, 8'h07, 16'h0023, 4, w);
        waitOutValid();
        tick();
        bus.out_ready = 1'b1;
        applyStimulus(8'h0F, 8'hF0, 16'h0E10, 4, w);
        checkOutput("b2b_same_cycle_accept", 32'(w), 0);
        waitDone();

        $display("[TB] reset during step2 of 0xAA*0x55");
        applyStimulus(8'hAA, 8'h55, 16'h3872, 4, w);
        tick();
        tick();
        rst = 1'b1;
        #1;
        if (sb.size() > 0) void'(sb.pop_back());
        checkOutput("midreset_out_valid", 32'(bus.out_valid), 0);
        checkOutput("midreset_busy", 32'(bus.busy), 0);
        checkOutput("midreset_in_ready", 32'(bus.in_ready), 1);
        checkOutput("midreset_product", 32'(bus.product), 0);
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checkOutput("post_reset_out_valid", 32'(bus.out_valid), 0);
        end
        tick();
        applyStimulus(8'h02, 8'h03, 16'h0006, 4, w);
        waitDone();

        $display("[TB] zero operand 0x00*0x7F");
        b0 = busy_cnt;
        applyStimulus(8'h00, 8'h7F, 16'h0000, ZERO_LAT, w);
        waitDone();
        checkOutput("busy_cycles_zero", 32'(busy_cnt - b0), 32'(ZERO_BUSY));

        $display("[TB] directed vector table");
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].a, vecs[i].b, vecs[i].prod, vecs[i].lat, w);
            waitDone();
        end

        tick();
        tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
